// File: rtl/reg_scoreboard.sv
// Dual-issue register scoreboard.
// Tracks which architectural registers have a write in flight. It stalls
// issue lanes A (older) and B (younger) on RAW and WAW hazards, both against
// the busy bitmap and between the two lanes. Writebacks clear busy bits.
module reg_scoreboard #(
  parameter int NREGS = 32,
  parameter int CNTW  = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             A_issue,
  input  logic [4:0]       A_rs1_addr,
  input  logic             A_rs1_used,
  input  logic [4:0]       A_rs2_addr,
  input  logic             A_rs2_used,
  input  logic [4:0]       A_rd_addr,
  input  logic             A_rd_write,
  input  logic             B_issue,
  input  logic [4:0]       B_rs1_addr,
  input  logic             B_rs1_used,
  input  logic [4:0]       B_rs2_addr,
  input  logic             B_rs2_used,
  input  logic [4:0]       B_rd_addr,
  input  logic             B_rd_write,
  input  logic             A_wb_valid,
  input  logic [4:0]       A_wb_addr,
  input  logic             B_wb_valid,
  input  logic [4:0]       B_wb_addr,
  output logic             A_stall,
  output logic             B_stall,
  output logic [NREGS-1:0] busy_vec,
  output logic [CNTW-1:0]  pending_count
);

  logic             a_src_busy;
  logic             a_waw_busy;
  logic             a_dest_live;
  logic             b_src_busy;
  logic             b_waw_busy;
  logic             pair_raw;
  logic             pair_waw;
  logic             a_accept;
  logic             b_accept;
  logic [NREGS-1:0] busy_next;
  logic [CNTW-1:0]  count_next;

  // Hazard detection. Only the registered bitmap is used, so a writeback in
  // the same cycle does not release a stall until the following cycle.
  // Bit 0 is never set, which is why x0 reads and writes never stall here.
  always_comb begin
    a_src_busy  = (A_rs1_used & busy_vec[A_rs1_addr]) |
                  (A_rs2_used & busy_vec[A_rs2_addr]);
    a_waw_busy  = A_rd_write & busy_vec[A_rd_addr];
    A_stall     = A_issue & (a_src_busy | a_waw_busy);

    // Lane A's destination only forms a pair hazard if it is a real write.
    a_dest_live = A_issue & A_rd_write & (A_rd_addr != 5'd0);
    b_src_busy  = (B_rs1_used & busy_vec[B_rs1_addr]) |
                  (B_rs2_used & busy_vec[B_rs2_addr]);
    b_waw_busy  = B_rd_write & busy_vec[B_rd_addr];
    pair_raw    = a_dest_live &
                  ((B_rs1_used & (B_rs1_addr == A_rd_addr)) |
                   (B_rs2_used & (B_rs2_addr == A_rd_addr)));
    pair_waw    = a_dest_live & B_rd_write & (B_rd_addr == A_rd_addr);

    // B is younger, so it can never move ahead of a stalled A.
    B_stall     = B_issue & (A_stall | b_src_busy | b_waw_busy | pair_raw | pair_waw);
  end

  // Next bitmap: clears first, then sets so a new issue wins over a writeback
  // of an older write to the same register. Flush overrides everything.
  always_comb begin
    busy_next = busy_vec;
    a_accept  = A_issue & ~A_stall;
    b_accept  = B_issue & ~B_stall;
    if (A_wb_valid) busy_next[A_wb_addr] = 1'b0;
    if (B_wb_valid) busy_next[B_wb_addr] = 1'b0;
    if (a_accept && A_rd_write) busy_next[A_rd_addr] = 1'b1;
    if (b_accept && B_rd_write) busy_next[B_rd_addr] = 1'b1;
    busy_next[0] = 1'b0;
    if (flush) busy_next = '0;
  end

  // Population count of the next bitmap so the count register tracks
  // busy_vec with no extra latency.
  always_comb begin
    count_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      count_next = count_next + CNTW'(busy_next[i]);
    end
  end

  // State registers; reset drops all pending writes immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_vec      <= '0;
      pending_count <= '0;
    end else begin
      busy_vec      <= busy_next;
      pending_count <= count_next;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed hazard scenarios plus a
// randomized run checked against a set-based reference model.
module tb_reg_scoreboard;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        A_issue, A_rs1_used, A_rs2_used, A_rd_write;
  logic [4:0]  A_rs1_addr, A_rs2_addr, A_rd_addr;
  logic        B_issue, B_rs1_used, B_rs2_used, B_rd_write;
  logic [4:0]  B_rs1_addr, B_rs2_addr, B_rd_addr;
  logic        A_wb_valid, B_wb_valid;
  logic [4:0]  A_wb_addr, B_wb_addr;
  logic        A_stall, B_stall;
  logic [31:0] busy_vec;
  logic [5:0]  pending_count;

  int checks;
  int failures;

  // Reference model: the set of registers with a write in flight.
  bit model_busy[32];

  reg_scoreboard #(.NREGS(32), .CNTW(6)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .A_issue(A_issue), .A_rs1_addr(A_rs1_addr), .A_rs1_used(A_rs1_used),
    .A_rs2_addr(A_rs2_addr), .A_rs2_used(A_rs2_used),
    .A_rd_addr(A_rd_addr), .A_rd_write(A_rd_write),
    .B_issue(B_issue), .B_rs1_addr(B_rs1_addr), .B_rs1_used(B_rs1_used),
    .B_rs2_addr(B_rs2_addr), .B_rs2_used(B_rs2_used),
    .B_rd_addr(B_rd_addr), .B_rd_write(B_rd_write),
    .A_wb_valid(A_wb_valid), .A_wb_addr(A_wb_addr),
    .B_wb_valid(B_wb_valid), .B_wb_addr(B_wb_addr),
    .A_stall(A_stall), .B_stall(B_stall),
    .busy_vec(busy_vec), .pending_count(pending_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    flush = 0;
    A_issue = 0; A_rs1_used = 0; A_rs2_used = 0; A_rd_write = 0;
    A_rs1_addr = 0; A_rs2_addr = 0; A_rd_addr = 0;
    B_issue = 0; B_rs1_used = 0; B_rs2_used = 0; B_rd_write = 0;
    B_rs1_addr = 0; B_rs2_addr = 0; B_rd_addr = 0;
    A_wb_valid = 0; A_wb_addr = 0; B_wb_valid = 0; B_wb_addr = 0;
  endtask

  task automatic do_flush();
    set_idle();
    flush = 1;
    tick();
    flush = 0;
  endtask

  task automatic randomize_inputs(input int max_reg);
    A_issue = 1'($urandom); A_rd_write = 1'($urandom);
    A_rs1_used = 1'($urandom); A_rs2_used = 1'($urandom);
    A_rs1_addr = 5'($urandom_range(0, max_reg));
    A_rs2_addr = 5'($urandom_range(0, max_reg));
    A_rd_addr  = 5'($urandom_range(0, max_reg));
    B_issue = 1'($urandom); B_rd_write = 1'($urandom);
    B_rs1_used = 1'($urandom); B_rs2_used = 1'($urandom);
    B_rs1_addr = 5'($urandom_range(0, max_reg));
    B_rs2_addr = 5'($urandom_range(0, max_reg));
    B_rd_addr  = 5'($urandom_range(0, max_reg));
    A_wb_valid = ($urandom_range(0, 2) == 0);
    B_wb_valid = ($urandom_range(0, 2) == 0);
    A_wb_addr  = 5'($urandom_range(0, max_reg));
    B_wb_addr  = 5'($urandom_range(0, max_reg));
  endtask

  function automatic logic [31:0] model_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = model_busy[i];
    return v;
  endfunction

  function automatic int model_count();
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) if (model_busy[i]) n++;
    return n;
  endfunction

  // An instruction must wait if any register it touches is still owed a write.
  function automatic bit model_a_waits();
    return A_issue && ((A_rs1_used && model_busy[A_rs1_addr]) ||
                       (A_rs2_used && model_busy[A_rs2_addr]) ||
                       (A_rd_write && model_busy[A_rd_addr]));
  endfunction

  // B waits behind A, behind the busy set, and behind whatever A is about to claim.
  function automatic bit model_b_waits();
    int claim;
    bit touches_busy, touches_claim;
    claim = (A_issue && A_rd_write && A_rd_addr != 0) ? int'(A_rd_addr) : -1;
    touches_busy = (B_rs1_used && model_busy[B_rs1_addr]) ||
                   (B_rs2_used && model_busy[B_rs2_addr]) ||
                   (B_rd_write && model_busy[B_rd_addr]);
    touches_claim = (claim > 0) && ((B_rs1_used && int'(B_rs1_addr) == claim) ||
                                    (B_rs2_used && int'(B_rs2_addr) == claim) ||
                                    (B_rd_write && int'(B_rd_addr) == claim));
    return B_issue && (model_a_waits() || touches_busy || touches_claim);
  endfunction

  // Apply one clock of events to the model set.
  task automatic model_step();
    bit a_go, b_go;
    a_go = A_issue && !model_a_waits();
    b_go = B_issue && !model_b_waits();
    if (flush) begin
      for (int i = 0; i < 32; i++) model_busy[i] = 0;
    end else begin
      if (A_wb_valid) model_busy[A_wb_addr] = 0;
      if (B_wb_valid) model_busy[B_wb_addr] = 0;
      if (a_go && A_rd_write && A_rd_addr != 0) model_busy[A_rd_addr] = 1;
      if (b_go && B_rd_write && B_rd_addr != 0) model_busy[B_rd_addr] = 1;
    end
  endtask

  task automatic test_reset();
    bit ea, eb;
    set_idle();
    reset_n = 1;
    #2 reset_n = 0;
    for (int i = 0; i < 32; i++) model_busy[i] = 0;
    for (int c = 0; c < 6; c++) begin
      randomize_inputs(31);
      #1;
      ea = model_a_waits();
      eb = model_b_waits();
      checks++;
      if (busy_vec !== 32'h0 || pending_count !== 6'd0) begin
        failures++;
        $display("[TB] FAIL reset_state busy=%h cnt=%0d expected busy=0 cnt=0", busy_vec, pending_count);
      end
      checks++;
      if (A_stall !== ea || B_stall !== eb) begin
        failures++;
        $display("[TB] FAIL reset_stall A=%b B=%b expected A=%b B=%b", A_stall, B_stall, ea, eb);
      end
      tick();
    end
    set_idle();
    #1 reset_n = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (busy_vec !== 32'h0 || pending_count !== 6'd0) begin
        failures++;
        $display("[TB] FAIL idle_after_reset cycle=%0d busy=%h cnt=%0d expected 0/0", c, busy_vec, pending_count);
      end
    end
  endtask

  task automatic test_raw_single();
    set_idle();
    A_issue = 1; A_rd_write = 1; A_rd_addr = 5;
    tick();
    checks++;
    if (busy_vec !== 32'h20 || pending_count !== 6'd1) begin
      failures++;
      $display("[TB] FAIL raw_set busy=%h cnt=%0d expected busy=00000020 cnt=1", busy_vec, pending_count);
    end
    A_rd_write = 0; A_rs1_used = 1; A_rs1_addr = 5;
    #1;
    checks++;
    if (A_stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL raw_stall A_stall=%b expected 1", A_stall);
    end
    A_wb_valid = 1; A_wb_addr = 5;
    #1;
    checks++;
    if (A_stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wb_no_bypass A_stall=%b expected 1", A_stall);
    end
    tick();
    A_wb_valid = 0;
    #1;
    checks++;
    if (busy_vec !== 32'h0 || pending_count !== 6'd0 || A_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL raw_release busy=%h cnt=%0d A_stall=%b expected 0/0/0", busy_vec, pending_count, A_stall);
    end
    set_idle();
    tick();
  endtask

  task automatic test_pair_hazards();
    do_flush();
    A_issue = 1; A_rd_write = 1; A_rd_addr = 3;
    B_issue = 1; B_rs1_used = 1; B_rs1_addr = 3;
    #1;
    checks++;
    if (A_stall !== 1'b0 || B_stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pair_raw A=%b B=%b expected A=0 B=1", A_stall, B_stall);
    end
    tick();
    checks++;
    if (busy_vec !== 32'h8) begin
      failures++;
      $display("[TB] FAIL pair_raw_busy busy=%h expected 00000008", busy_vec);
    end
    do_flush();
    A_issue = 1; A_rd_write = 1; A_rd_addr = 7;
    B_issue = 1; B_rd_write = 1; B_rd_addr = 7;
    #1;
    checks++;
    if (A_stall !== 1'b0 || B_stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pair_waw A=%b B=%b expected A=0 B=1", A_stall, B_stall);
    end
    tick();
    checks++;
    if (busy_vec !== 32'h80 || pending_count !== 6'd1) begin
      failures++;
      $display("[TB] FAIL pair_waw_busy busy=%h cnt=%0d expected 00000080/1", busy_vec, pending_count);
    end
    do_flush();
    A_issue = 1; A_rd_write = 1; A_rd_addr = 0;
    B_issue = 1; B_rs1_used = 1; B_rs1_addr = 0;
    #1;
    checks++;
    if (A_stall !== 1'b0 || B_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL x0_pair A=%b B=%b expected A=0 B=0", A_stall, B_stall);
    end
    tick();
    checks++;
    if (busy_vec !== 32'h0 || pending_count !== 6'd0) begin
      failures++;
      $display("[TB] FAIL x0_busy busy=%h cnt=%0d expected 0/0", busy_vec, pending_count);
    end
    set_idle();
  endtask

  task automatic test_set_vs_clear();
    do_flush();
    A_issue = 1; A_rd_write = 1; A_rd_addr = 9;
    tick();
    set_idle();
    B_issue = 1; B_rd_write = 1; B_rd_addr = 9;
    #1;
    checks++;
    if (B_stall !== 1'b1 || A_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL waw_busy_b A=%b B=%b expected A=0 B=1", A_stall, B_stall);
    end
    set_idle();
    A_wb_valid = 1; A_wb_addr = 9;
    tick();
    set_idle();
    A_issue = 1; A_rd_write = 1; A_rd_addr = 9;
    B_wb_valid = 1; B_wb_addr = 9;
    tick();
    checks++;
    if (busy_vec !== 32'h200 || pending_count !== 6'd1) begin
      failures++;
      $display("[TB] FAIL set_beats_clear busy=%h cnt=%0d expected 00000200/1", busy_vec, pending_count);
    end
    set_idle();
  endtask

  task automatic test_dual_wb();
    do_flush();
    A_issue = 1; A_rd_write = 1; A_rd_addr = 1;
    B_issue = 1; B_rd_write = 1; B_rd_addr = 2;
    tick();
    set_idle();
    checks++;
    if (busy_vec !== 32'h6 || pending_count !== 6'd2) begin
      failures++;
      $display("[TB] FAIL dual_set busy=%h cnt=%0d expected 00000006/2", busy_vec, pending_count);
    end
    A_wb_valid = 1; A_wb_addr = 1; B_wb_valid = 1; B_wb_addr = 2;
    tick();
    set_idle();
    checks++;
    if (busy_vec !== 32'h0 || pending_count !== 6'd0) begin
      failures++;
      $display("[TB] FAIL dual_clear busy=%h cnt=%0d expected 0/0", busy_vec, pending_count);
    end
    A_issue = 1; A_rd_write = 1; A_rd_addr = 1;
    B_issue = 1; B_rd_write = 1; B_rd_addr = 2;
    tick();
    set_idle();
    A_wb_valid = 1; A_wb_addr = 1; B_wb_valid = 1; B_wb_addr = 1;
    tick();
    set_idle();
    checks++;
    if (busy_vec !== 32'h4 || pending_count !== 6'd1) begin
      failures++;
      $display("[TB] FAIL same_addr_clear busy=%h cnt=%0d expected 00000004/1", busy_vec, pending_count);
    end
  endtask

  task automatic fill_all();
    for (int r = 1; r < 32; r += 2) begin
      set_idle();
      A_issue = 1; A_rd_write = 1; A_rd_addr = 5'(r);
      if (r + 1 < 32) begin
        B_issue = 1; B_rd_write = 1; B_rd_addr = 5'(r + 1);
      end
      tick();
    end
    set_idle();
  endtask

  task automatic test_flush_reset();
    do_flush();
    fill_all();
    checks++;
    if (busy_vec !== 32'hFFFF_FFFE || pending_count !== 6'd31) begin
      failures++;
      $display("[TB] FAIL fill busy=%h cnt=%0d expected fffffffe/31", busy_vec, pending_count);
    end
    flush = 1;
    A_issue = 1; A_rd_write = 1; A_rd_addr = 4;
    tick();
    set_idle();
    checks++;
    if (busy_vec !== 32'h0 || pending_count !== 6'd0) begin
      failures++;
      $display("[TB] FAIL flush busy=%h cnt=%0d expected 0/0", busy_vec, pending_count);
    end
    fill_all();
    checks++;
    if (pending_count !== 6'd31) begin
      failures++;
      $display("[TB] FAIL refill cnt=%0d expected 31", pending_count);
    end
    #1 reset_n = 0;
    #1;
    checks++;
    if (busy_vec !== 32'h0 || pending_count !== 6'd0) begin
      failures++;
      $display("[TB] FAIL async_reset busy=%h cnt=%0d expected 0/0", busy_vec, pending_count);
    end
    #1 reset_n = 1;
    tick();
    checks++;
    if (busy_vec !== 32'h0 || pending_count !== 6'd0) begin
      failures++;
      $display("[TB] FAIL post_reset busy=%h cnt=%0d expected 0/0", busy_vec, pending_count);
    end
  endtask

  task automatic test_random();
    bit ea, eb;
    logic [31:0] ev;
    int ec;
    do_flush();
    for (int i = 0; i < 32; i++) model_busy[i] = 0;
    for (int c = 0; c < 400; c++) begin
      randomize_inputs((c < 200) ? 7 : 31);
      flush = ($urandom_range(0, 24) == 0);
      #1;
      ea = model_a_waits();
      eb = model_b_waits();
      checks++;
      if (A_stall !== ea || B_stall !== eb) begin
        failures++;
        $display("[TB] FAIL rand_stall cycle=%0d A=%b B=%b expected A=%b B=%b", c, A_stall, B_stall, ea, eb);
      end
      model_step();
      tick();
      ev = model_vec();
      ec = model_count();
      checks++;
      if (busy_vec !== ev || pending_count !== 6'(ec)) begin
        failures++;
        $display("[TB] FAIL rand_state cycle=%0d busy=%h cnt=%0d expected busy=%h cnt=%0d", c, busy_vec, pending_count, ev, ec);
      end
    end
    set_idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    set_idle();
    test_reset();
    test_raw_single();
    test_pair_hazards();
    test_set_vs_clear();
    test_dual_wb();
    test_flush_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Dual-issue register scoreboard that sits in front of the dual-port register file and tracks which architectural registers have writes in flight.
- Issue lanes A (older) and B (younger) present their operands each cycle. The block returns per-lane stall decisions and marks destinations busy on accept.
- Writeback lanes A and B clear busy bits when results are written to the register file.
- Enforces RAW and WAW ordering for the in-order dual-issue pipeline.

Parameters:
- NREGS, 32, number of architectural registers (address width fixed at 5).
- CNTW, 6, width of pending_count.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all busy bits (pipeline flush).
- A_issue  input  1  lane A has a valid instruction at issue.
- A_rs1_addr  input  5  lane A source 1.
- A_rs1_used  input  1  lane A reads rs1.
- A_rs2_addr  input  5  lane A source 2.
- A_rs2_used  input  1  lane A reads rs2.
- A_rd_addr  input  5  lane A destination.
- A_rd_write  input  1  lane A writes rd.
- B_issue, B_rs1_addr, B_rs1_used, B_rs2_addr, B_rs2_used, B_rd_addr, B_rd_write  input  1/5/1/5/1/5/1  same as lane A, for lane B.
- A_wb_valid  input  1  lane A writeback this cycle.
- A_wb_addr  input  5  lane A writeback register.
- B_wb_valid  input  1  lane B writeback this cycle.
- B_wb_addr  input  5  lane B writeback register.
- A_stall  output  1  lane A must hold (combinational).
- B_stall  output  1  lane B must hold (combinational).
- busy_vec  output  32  registered busy bitmap; bit i set means register i has a pending write.
- pending_count  output  CNTW  registered popcount of busy_vec.

Behaviour:
- Reset (reset_n low, asynchronous): busy_vec=0, pending_count=0.
- Stall outputs while in reset: A_stall and B_stall follow their combinational equations with busy_vec=0.
- Register 0 is never busy. Any set or clear targeting address 0 is ignored. Reads of x0 never stall.
- A_stall = A_issue & ( (A_rs1_used & busy[A_rs1_addr]) | (A_rs2_used & busy[A_rs2_addr]) | (A_rd_write & busy[A_rd_addr]) ).
- B_stall = B_issue & ( A_stall | B_src_busy | B_waw_busy | pair_raw | pair_waw ), where:
  - B_src_busy: a used B source is busy.
  - B_waw_busy: B_rd_write & busy[B_rd_addr].
  - pair_raw: A_issue & A_rd_write & A_rd_addr!=0 & a used B source equals A_rd_addr.
  - pair_waw: A_issue & A_rd_write & B_rd_write & A_rd_addr==B_rd_addr!=0.
  - B never issues ahead of A.
- Stall equations use the current registered busy_vec only. A same-cycle writeback does not un-stall; the stall releases one cycle later. There is no bypass from writeback into the stall logic.
- Accept rules:
  - Lane A accepted = A_issue & ~A_stall.
  - Lane B accepted = B_issue & ~B_stall.
  - On accept with rd_write and rd!=0, the rd bit is set at the next rising edge.
- Clears: A_wb_valid / B_wb_valid clear the bit at A_wb_addr / B_wb_addr at the next rising edge.
- Simultaneous events on the same bit:
  - Set beats clear: a new issue and a writeback of an older write to the same register leave the bit set.
  - Both WB lanes clearing the same address is legal; the bit clears once.
- Clearing an already-clear bit is a no-op. No error is flagged.
- flush has priority over all sets and clears. On the next edge busy_vec=0 and pending_count=0. Issues presented in the flush cycle do not set bits.
- pending_count is registered and equals the popcount of the next busy_vec (zero latency relative to busy_vec). Maximum value 31, no overflow.
- Latency: issue to busy visible is 1 cycle. Writeback to busy cleared is 1 cycle. Writeback to stall released is 1 cycle.
- reset_n asserted mid-operation drops all busy state immediately, without waiting for a clock edge.

Test Plan:
- Reset then idle: hold reset_n=0 with random inputs -> busy_vec=0, pending_count=0. Release with no activity -> values unchanged for 10 cycles.
- Lane A writes x5, next cycle lane A reads x5:
  - busy_vec=0x20, pending_count=1, A_stall=1.
  - A_wb_valid with addr 5 -> busy_vec=0 next edge, A_stall=0 the cycle after.
- Pair hazards:
  - A writes x3, B reads x3 same cycle -> A_stall=0, B_stall=1, busy_vec=0x8.
  - Separately, A and B both write x7 -> B_stall=1.
  - A writes x0 and B reads x0 -> no stall, busy_vec unchanged.
- Set-vs-clear: x9 busy; same cycle, lane B issues a write to x9 (not stalled because x9 busy? expect B_stall=1) -> verify the stall.
  - Then release and issue a write to x9 concurrent with B_wb of x9 -> bit 9 stays set, pending_count=1.
- Dual writeback: x1 and x2 busy; both WB lanes target x1 and x2 -> busy_vec=0 and pending_count=0 next edge. Both lanes targeting x1 -> only bit 1 cleared.
- Flush and async reset:
  - Fill x1..x31 busy -> pending_count=31.
  - Assert flush together with an A issue to x4 -> busy_vec=0 next edge.
  - Refill, then pulse reset_n low between edges -> busy_vec=0 immediately.
